as_gpio_port: RTL and testbench

Memory-mapped GPIO responder on the RV64I core's data bus. It decodes load/store requests from the core, holds output and direction registers, drives the bidirectional `gpio_io` pins and pulses `cs_o` for one cycle on every write to the output register; the testbench GPIO monitor samples that pulse. It also synchronises pin inputs, captures rising edges into sticky status bits and raises a level interrupt.

---
 rtl/as_pack.sv | 44 ++++
 rtl/as_gpio_sync.sv | 31 +++
 rtl/as_gpio_port.sv | 118 +++++++++++
 tb/tb_as_gpio_port.sv | 250 +++++++++++++++++++++++++
 4 files changed

// File: rtl/as_pack.sv
// Shared constants, register-select enum and decode helpers for the GPIO port.
package as_pack;

    localparam int unsigned nr_gpios        = 8;
    localparam int unsigned gpio_addr_width = 6;

    localparam logic [63:0] GPIO_OUT_OFS  = 64'h00;
    localparam logic [63:0] GPIO_DIR_OFS  = 64'h08;
    localparam logic [63:0] GPIO_IN_OFS   = 64'h10;
    localparam logic [63:0] GPIO_EDGE_OFS = 64'h18;
    localparam logic [63:0] GPIO_IEN_OFS  = 64'h20;

    typedef enum logic [2:0] {
        RegOut,
        RegDir,
        RegIn,
        RegEdge,
        RegIen,
        RegNone
    } gpio_reg_e;

    // Registers are 8 bytes wide, so the low three offset bits never select anything.
    function automatic gpio_reg_e gpio_decode(input logic [63:0] ofs);
        gpio_reg_e r;
        case (ofs & ~64'h7)
            GPIO_OUT_OFS:  r = RegOut;
            GPIO_DIR_OFS:  r = RegDir;
            GPIO_IN_OFS:   r = RegIn;
            GPIO_EDGE_OFS: r = RegEdge;
            GPIO_IEN_OFS:  r = RegIen;
            default:       r = RegNone;
        endcase
        return r;
    endfunction

    function automatic logic [63:0] be_to_mask(input logic [7:0] be);
        logic [63:0] m;
        for (int i = 0; i < 8; i++) begin
            m[8*i +: 8] = {8{be[i]}};
        end
        return m;
    endfunction

endpackage

// File: rtl/as_gpio_sync.sv
// Two-flop input synchroniser with a previous-value register for rising-edge detection.
module as_gpio_sync #(
    parameter int unsigned Width = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [Width-1:0] d_i,
    output logic [Width-1:0] q_o,
    output logic [Width-1:0] rise_o
);

    logic [Width-1:0] meta_q;
    logic [Width-1:0] sync_q;
    logic [Width-1:0] prev_q;

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            meta_q <= '0;
            sync_q <= '0;
            prev_q <= '0;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
            prev_q <= sync_q;
        end
    end

    assign q_o    = sync_q;
    assign rise_o = sync_q & ~prev_q;

endmodule

// File: rtl/as_gpio_port.sv
// Memory-mapped GPIO port: OUT/DIR/IN/EDGE/IEN registers, tristate pads, edge interrupt.
module as_gpio_port
    import as_pack::*;
#(
    parameter int unsigned NR_GPIOS = nr_gpios,
    parameter int unsigned ADDR_W   = gpio_addr_width
) (
    input  logic                clk_i,
    input  logic                rst_i,
    input  logic                sel_i,
    input  logic                we_i,
    input  logic [ADDR_W-1:0]   addr_i,
    input  logic [63:0]         wdata_i,
    input  logic [7:0]          be_i,
    output logic [63:0]         rdata_o,
    output logic                ack_o,
    inout  wire  [NR_GPIOS-1:0] gpio_io,
    output logic                cs_o,
    output logic                irq_o
);

    logic [NR_GPIOS-1:0] out_q, out_d;
    logic [NR_GPIOS-1:0] dir_q, dir_d;
    logic [NR_GPIOS-1:0] ien_q, ien_d;
    logic [NR_GPIOS-1:0] edge_q, edge_d;
    logic [NR_GPIOS-1:0] pin_in, in_sync, in_rise;
    logic [NR_GPIOS-1:0] wmask, wbits;
    logic [63:0]         wmask_full;
    logic [63:0]         rdata_q, rdata_d;
    logic                ack_q, cs_q, cs_d, wr_en;
    gpio_reg_e           reg_sel;

    as_gpio_sync #(
        .Width (NR_GPIOS)
    ) u_sync (
        .clk_i  (clk_i),
        .rst_i  (rst_i),
        .d_i    (pin_in),
        .q_o    (in_sync),
        .rise_o (in_rise)
    );

    always_comb begin
        reg_sel    = gpio_decode(64'(addr_i));
        wr_en      = sel_i & we_i;
        wmask_full = be_to_mask(be_i);
        wmask      = wmask_full[NR_GPIOS-1:0];
        wbits      = wdata_i[NR_GPIOS-1:0] & wmask;
        cs_d       = wr_en && (reg_sel == RegOut) && (|be_i);
    end

    // Edge flags are set every cycle; a W1C in the same cycle cannot hide a new edge.
    always_comb begin
        out_d  = out_q;
        dir_d  = dir_q;
        ien_d  = ien_q;
        edge_d = edge_q | in_rise;
        if (wr_en) begin
            unique case (reg_sel)
                RegOut:  out_d  = (out_q & ~wmask) | wbits;
                RegDir:  dir_d  = (dir_q & ~wmask) | wbits;
                RegEdge: edge_d = (edge_q & ~wbits) | in_rise;
                RegIen:  ien_d  = (ien_q & ~wmask) | wbits;
                default: ;
            endcase
        end
    end

    always_comb begin
        rdata_d = '0;
        if (sel_i && !we_i) begin
            unique case (reg_sel)
                RegOut:  rdata_d[NR_GPIOS-1:0] = out_q;
                RegDir:  rdata_d[NR_GPIOS-1:0] = dir_q;
                RegIn:   rdata_d[NR_GPIOS-1:0] = in_sync;
                RegEdge: rdata_d[NR_GPIOS-1:0] = edge_q;
                RegIen:  rdata_d[NR_GPIOS-1:0] = ien_q;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            out_q   <= '0;
            dir_q   <= '0;
            ien_q   <= '0;
            edge_q  <= '0;
            rdata_q <= '0;
            ack_q   <= 1'b0;
            cs_q    <= 1'b0;
        end else begin
            out_q   <= out_d;
            dir_q   <= dir_d;
            ien_q   <= ien_d;
            edge_q  <= edge_d;
            rdata_q <= rdata_d;
            ack_q   <= sel_i;
            cs_q    <= cs_d;
        end
    end

    for (genvar i = 0; i < NR_GPIOS; i++) begin : g_pad
        assign gpio_io[i] = dir_q[i] ? out_q[i] : 1'bz;
    end

    assign pin_in  = gpio_io;
    assign rdata_o = rdata_q;
    assign ack_o   = ack_q;
    assign cs_o    = cs_q;
    assign irq_o   = |(edge_q & ien_q);

    if (NR_GPIOS < 64) begin : g_unused
        logic unused_hi;
        assign unused_hi = ^{wdata_i[63:NR_GPIOS], wmask_full[63:NR_GPIOS]};
    end

endmodule

// File: tb/tb_as_gpio_port.sv
// Self-checking bench for as_gpio_port: directed scenarios plus a randomized run against a model.
module tb_as_gpio_port;

    localparam int unsigned N = 8;

    logic        clk_i   = 1'b0;
    logic        rst_i   = 1'b1;
    logic        sel_i   = 1'b0;
    logic        we_i    = 1'b0;
    logic [5:0]  addr_i  = '0;
    logic [63:0] wdata_i = '0;
    logic [7:0]  be_i    = '0;
    logic [63:0] rdata_o;
    logic        ack_o, cs_o, irq_o;
    wire  [N-1:0] gpio;
    logic [N-1:0] tb_pin = '0;

    int unsigned n_vec = 0;
    int unsigned n_err = 0;

    // Reference model: register contents plus the pin value seen on the last edges.
    logic [N-1:0] m_out = '0, m_dir = '0, m_ien = '0, m_edge = '0;
    logic [N-1:0] hist0 = '0, hist1 = '0, hist2 = '0;
    logic         exp_ack = 1'b0, exp_cs = 1'b0;
    logic [63:0]  exp_rdata = '0;

    always #5 clk_i = ~clk_i;

    for (genvar i = 0; i < N; i++) begin : g_drv
        assign gpio[i] = m_dir[i] ? 1'bz : tb_pin[i];
    end

    as_gpio_port dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .sel_i   (sel_i),
        .we_i    (we_i),
        .addr_i  (addr_i),
        .wdata_i (wdata_i),
        .be_i    (be_i),
        .rdata_o (rdata_o),
        .ack_o   (ack_o),
        .gpio_io (gpio),
        .cs_o    (cs_o),
        .irq_o   (irq_o)
    );

    function automatic logic [N-1:0] model_read(input logic [5:0] a);
        case (a[5:3])
            3'd0:    return m_out;
            3'd1:    return m_dir;
            3'd2:    return hist1;
            3'd3:    return m_edge;
            3'd4:    return m_ien;
            default: return '0;
        endcase
    endfunction

    // hist1 is the pin two edges back (IN); a rise is IN high after it was low one edge earlier.
    always @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            m_out <= '0; m_dir <= '0; m_ien <= '0; m_edge <= '0;
            hist0 <= '0; hist1 <= '0; hist2 <= '0;
            exp_ack <= 1'b0; exp_cs <= 1'b0; exp_rdata <= '0;
        end else begin
            hist0     <= gpio;
            hist1     <= hist0;
            hist2     <= hist1;
            exp_ack   <= sel_i;
            exp_cs    <= sel_i && we_i && (addr_i[5:3] == 3'd0) && (be_i != 8'h00);
            exp_rdata <= (sel_i && !we_i) ? {56'b0, model_read(addr_i)} : 64'b0;
            m_edge    <= m_edge | (hist1 & ~hist2);
            if (sel_i && we_i && be_i[0]) begin
                case (addr_i[5:3])
                    3'd0: m_out  <= wdata_i[N-1:0];
                    3'd1: m_dir  <= wdata_i[N-1:0];
                    3'd3: m_edge <= (m_edge & ~wdata_i[N-1:0]) | (hist1 & ~hist2);
                    3'd4: m_ien  <= wdata_i[N-1:0];
                    default: ;
                endcase
            end
        end
    end

    task automatic tick;
        @(posedge clk_i);
        #1;
    endtask

    task automatic req(input logic w, input logic [5:0] a, input logic [63:0] d,
                       input logic [7:0] b);
        sel_i = 1'b1; we_i = w; addr_i = a; wdata_i = d; be_i = b;
    endtask

    task automatic idle;
        sel_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; be_i = '0;
    endtask

    task automatic test_reset;
        logic [5:0] ofs [3] = '{6'h00, 6'h08, 6'h10};
        #2 rst_i = 1'b0;
        tick; tick;
        n_vec++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack: got %b, want 0", ack_o); end
        n_vec++; if (cs_o !== 1'b0) begin n_err++; $display("FAIL reset_cs: got %b, want 0", cs_o); end
        n_vec++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL reset_irq: got %b, want 0", irq_o); end
        n_vec++; if (rdata_o !== 64'h0) begin n_err++; $display("FAIL reset_rdata: got %h, want 0", rdata_o); end
        rst_i = 1'b1;
        tick;
        for (int i = 0; i < 3; i++) begin
            req(1'b0, ofs[i], 64'h0, 8'h00);
            n_vec++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL reset_ack_early: got %b, want 0", ack_o); end
            tick;
            idle;
            n_vec++; if (ack_o !== 1'b1) begin n_err++; $display("FAIL reset_load_ack: got %b, want 1", ack_o); end
            n_vec++; if (rdata_o !== 64'h0) begin n_err++; $display("FAIL reset_load_data ofs %h: got %h, want 0", ofs[i], rdata_o); end
            n_vec++; if (cs_o !== 1'b0) begin n_err++; $display("FAIL reset_load_cs: got %b, want 0", cs_o); end
            tick;
        end
    endtask

    task automatic test_out_dir;
        req(1'b1, 6'h08, 64'hFF, 8'h01); tick;
        req(1'b1, 6'h00, 64'h1234_5678_9ABC_DE80, 8'h01); tick;
        idle;
        n_vec++; if (cs_o !== 1'b1) begin n_err++; $display("FAIL out_cs: got %b, want 1", cs_o); end
        n_vec++; if (gpio !== 8'h80) begin n_err++; $display("FAIL out_pins: got %h, want 80", gpio); end
        tick;
        n_vec++; if (cs_o !== 1'b0) begin n_err++; $display("FAIL out_cs_once: got %b, want 0", cs_o); end
        req(1'b0, 6'h00, 64'h0, 8'h00); tick;
        n_vec++; if (rdata_o !== 64'h80) begin n_err++; $display("FAIL out_load: got %h, want 80", rdata_o); end
        req(1'b1, 6'h00, 64'h3C, 8'h00); tick;
        n_vec++; if (ack_o !== 1'b1) begin n_err++; $display("FAIL out_be0_ack: got %b, want 1", ack_o); end
        n_vec++; if (cs_o !== 1'b0) begin n_err++; $display("FAIL out_be0_cs: got %b, want 0", cs_o); end
        req(1'b0, 6'h00, 64'h0, 8'h00); tick;
        idle;
        n_vec++; if (rdata_o !== 64'h80) begin n_err++; $display("FAIL out_be0_keep: got %h, want 80", rdata_o); end
        tick;
    endtask

    task automatic test_back_to_back;
        for (int i = 1; i <= 7; i++) begin
            req(1'b1, 6'h00, 64'(i), 8'h01);
            tick;
            n_vec++; if (ack_o !== 1'b1) begin n_err++; $display("FAIL b2b_ack %0d: got %b, want 1", i, ack_o); end
            n_vec++; if (cs_o !== 1'b1) begin n_err++; $display("FAIL b2b_cs %0d: got %b, want 1", i, cs_o); end
            n_vec++; if (gpio !== 8'(i)) begin n_err++; $display("FAIL b2b_pins: got %h, want %h", gpio, 8'(i)); end
        end
        idle; tick;
        n_vec++; if (cs_o !== 1'b0) begin n_err++; $display("FAIL b2b_cs_end: got %b, want 0", cs_o); end
    endtask

    task automatic test_edge_irq;
        tb_pin = '0;
        req(1'b1, 6'h08, 64'h00, 8'h01); tick;
        req(1'b1, 6'h20, 64'h04, 8'h01); tick;
        idle; repeat (4) tick;
        req(1'b1, 6'h18, 64'hFF, 8'h01); tick;
        idle; tick;
        n_vec++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL edge_irq_idle: got %b, want 0", irq_o); end
        tb_pin[2] = 1'b1;
        req(1'b0, 6'h10, 64'h0, 8'h00);
        tick;
        n_vec++; if (rdata_o !== 64'h0) begin n_err++; $display("FAIL edge_in_1: got %h, want 0", rdata_o); end
        tick;
        n_vec++; if (rdata_o !== 64'h0) begin n_err++; $display("FAIL edge_in_2: got %h, want 0", rdata_o); end
        n_vec++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL edge_irq_early: got %b, want 0", irq_o); end
        tick;
        n_vec++; if (rdata_o !== 64'h04) begin n_err++; $display("FAIL edge_in_3: got %h, want 04", rdata_o); end
        n_vec++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL edge_irq: got %b, want 1", irq_o); end
        req(1'b0, 6'h18, 64'h0, 8'h00); tick;
        n_vec++; if (rdata_o !== 64'h04) begin n_err++; $display("FAIL edge_flag: got %h, want 04", rdata_o); end
        req(1'b1, 6'h18, 64'h04, 8'h01); tick;
        n_vec++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL edge_w1c_irq: got %b, want 0", irq_o); end
        req(1'b0, 6'h18, 64'h0, 8'h00); tick;
        idle;
        n_vec++; if (rdata_o !== 64'h0) begin n_err++; $display("FAIL edge_w1c: got %h, want 0", rdata_o); end
        tick;
    endtask

    task automatic test_set_wins;
        tb_pin[2] = 1'b0;
        repeat (4) tick;
        tb_pin[2] = 1'b1;
        tick; tick;
        req(1'b1, 6'h18, 64'h04, 8'h01); tick;
        n_vec++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL setwins_irq: got %b, want 1", irq_o); end
        req(1'b0, 6'h18, 64'h0, 8'h00); tick;
        idle;
        n_vec++; if (rdata_o !== 64'h04) begin n_err++; $display("FAIL setwins_flag: got %h, want 04", rdata_o); end
        tick;
    endtask

    task automatic test_reset_abort;
        n_vec++; if (irq_o !== 1'b1) begin n_err++; $display("FAIL abort_pre_irq: got %b, want 1", irq_o); end
        req(1'b1, 6'h00, 64'h55, 8'hFF);
        #3 rst_i = 1'b0;
        @(posedge clk_i); #1;
        n_vec++; if (ack_o !== 1'b0) begin n_err++; $display("FAIL abort_ack: got %b, want 0", ack_o); end
        n_vec++; if (cs_o !== 1'b0) begin n_err++; $display("FAIL abort_cs: got %b, want 0", cs_o); end
        n_vec++; if (irq_o !== 1'b0) begin n_err++; $display("FAIL abort_irq: got %b, want 0", irq_o); end
        idle;
        #2 rst_i = 1'b1;
        tick;
        req(1'b0, 6'h00, 64'h0, 8'h00); tick;
        n_vec++; if (rdata_o !== 64'h0) begin n_err++; $display("FAIL abort_out: got %h, want 0", rdata_o); end
        req(1'b0, 6'h30, 64'h0, 8'h00); tick;
        idle;
        n_vec++; if (ack_o !== 1'b1) begin n_err++; $display("FAIL unmapped_ack: got %b, want 1", ack_o); end
        n_vec++; if (rdata_o !== 64'h0) begin n_err++; $display("FAIL unmapped_data: got %h, want 0", rdata_o); end
        tick;
    endtask

    task automatic test_random;
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 3) == 0) tb_pin = N'($urandom);
            if ($urandom_range(0, 4) == 0) begin
                idle;
            end else begin
                req(1'($urandom_range(0, 1)), 6'($urandom_range(0, 63)), {$urandom, $urandom},
                    ($urandom_range(0, 3) == 0) ? 8'h00 : 8'($urandom));
            end
            tick;
            n_vec++; if (ack_o !== exp_ack) begin n_err++; $display("FAIL rnd_ack @%0d: got %b, want %b", i, ack_o, exp_ack); end
            n_vec++; if (cs_o !== exp_cs) begin n_err++; $display("FAIL rnd_cs @%0d: got %b, want %b", i, cs_o, exp_cs); end
            n_vec++; if (rdata_o !== exp_rdata) begin n_err++; $display("FAIL rnd_rdata @%0d: got %h, want %h", i, rdata_o, exp_rdata); end
            n_vec++; if (irq_o !== |(m_edge & m_ien)) begin n_err++; $display("FAIL rnd_irq @%0d: got %b, want %b", i, irq_o, |(m_edge & m_ien)); end
            n_vec++; if ((gpio & m_dir) !== (m_out & m_dir)) begin n_err++; $display("FAIL rnd_pins @%0d: got %h, want %h", i, gpio & m_dir, m_out & m_dir); end
        end
        idle; tick;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset;
        test_out_dir;
        test_back_to_back;
        test_edge_irq;
        test_set_wins;
        test_reset_abort;
        test_random;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
